uart_rx_fsm: RTL

Receive-side sequencer for the UART RX path. It detects a start bit, runs the oversampling edge and bit counters, and drives the enables for the data sampler, deserializer and start/parity/stop checkers. It issues a one-cycle `data_valid` when a frame completes without error. It sits between the `rx_in` pin logic and the deserializer/checker datapath, with one instance per UART receiver.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_edge_bit_counter.sv | 48 ++++
 rtl/uart_rx_fsm.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the UART receive path: state encoding, default widths
// and the set of legal oversampling ratios.
package uart_pkg;

   localparam int unsigned SAMPLING_BITS = 6;
   localparam int unsigned BIT_CNT_W     = 4;
   localparam int unsigned FRAME_DATA    = 8;

   localparam int unsigned PRESCALE_MIN = 8;
   localparam int unsigned PRESCALE_MID = 16;
   localparam int unsigned PRESCALE_MAX = 32;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] START  = 3'd1;
   localparam logic [2:0] DATA   = 3'd2;
   localparam logic [2:0] PARITY = 3'd3;
   localparam logic [2:0] STOP   = 3'd4;
   localparam logic [2:0] VALID  = 3'd5;

   function automatic logic legal_prescale(input int unsigned p);
      return (p == PRESCALE_MIN) || (p == PRESCALE_MID) || (p == PRESCALE_MAX);
   endfunction

endpackage

// File: rtl/uart_edge_bit_counter.sv
// Oversample edge counter and frame bit counter for the UART receiver.
// The bit count saturates at frame_data+1 so parity and stop share that index.
module uart_edge_bit_counter
   import uart_pkg::*;
#(
   parameter int unsigned sampling_bits = SAMPLING_BITS,
   parameter int unsigned bit_cnt_w     = BIT_CNT_W,
   parameter int unsigned frame_data    = FRAME_DATA
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic                     clear,
   input  logic                     load_edge1,
   input  logic [sampling_bits-1:0] prescale,
   output logic [sampling_bits-1:0] edge_cnt,
   output logic [bit_cnt_w-1:0]     bit_cnt,
   output logic                     last_edge_c
);

   localparam logic [bit_cnt_w-1:0] BIT_LAST = bit_cnt_w'(frame_data + 1);

   assign last_edge_c = (edge_cnt == (prescale - sampling_bits'(1)));

   // clear wins over load, load wins over counting
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         edge_cnt <= '0;
         bit_cnt  <= '0;
      end else if (clear) begin
         edge_cnt <= '0;
         bit_cnt  <= '0;
      end else if (load_edge1) begin
         edge_cnt <= sampling_bits'(1);
         bit_cnt  <= '0;
      end else if (enable) begin
         if (last_edge_c) begin
            edge_cnt <= '0;
            if (bit_cnt != BIT_LAST) begin
               bit_cnt <= bit_cnt + bit_cnt_w'(1);
            end
         end else begin
            edge_cnt <= edge_cnt + sampling_bits'(1);
         end
      end
   end

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive sequencer: start detection, frame sequencing, checker strobes
// and a one-cycle data_valid for each frame accepted without error.
module uart_rx_fsm
   import uart_pkg::*;
#(
   parameter int unsigned sampling_bits = SAMPLING_BITS,
   parameter int unsigned bit_cnt_w     = BIT_CNT_W,
   parameter int unsigned frame_data    = FRAME_DATA
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     rx_in,
   input  logic                     par_en,
   input  logic [sampling_bits-1:0] prescale,
   input  logic                     strt_glitch,
   input  logic                     par_err,
   input  logic                     stp_err,
   output logic                     dat_samp_en,
   output logic                     deser_en,
   output logic                     strt_chk_en,
   output logic                     par_chk_en,
   output logic                     stp_chk_en,
   output logic [sampling_bits-1:0] edge_cnt,
   output logic [bit_cnt_w-1:0]     bit_cnt,
   output logic                     data_valid
);

   logic [2:0]               state;
   logic [2:0]               state_n;
   logic [sampling_bits-1:0] p_lat;
   logic                     pe_lat;
   logic [sampling_bits-1:0] p_sane_c;
   logic                     cfg_load_c;
   logic                     cnt_en_c;
   logic                     cnt_clear_c;
   logic                     cnt_load1_c;
   logic                     last_edge_c;
   logic                     pre_last_c;
   logic                     last_data_c;

   // an unsupported ratio falls back to the slowest-safe minimum
   assign p_sane_c    = legal_prescale(32'(prescale)) ? prescale
                                                      : sampling_bits'(PRESCALE_MIN);
   assign pre_last_c  = (edge_cnt == (p_lat - sampling_bits'(2)));
   assign last_data_c = (bit_cnt == bit_cnt_w'(frame_data));

   uart_edge_bit_counter #(
      .sampling_bits (sampling_bits),
      .bit_cnt_w     (bit_cnt_w),
      .frame_data    (frame_data)
   ) u_counter (
      .clk         (clk),
      .rst         (rst),
      .enable      (cnt_en_c),
      .clear       (cnt_clear_c),
      .load_edge1  (cnt_load1_c),
      .prescale    (p_lat),
      .edge_cnt    (edge_cnt),
      .bit_cnt     (bit_cnt),
      .last_edge_c (last_edge_c)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // configuration is frozen for the whole frame once START is entered
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         p_lat  <= sampling_bits'(PRESCALE_MIN);
         pe_lat <= 1'b0;
      end else if (cfg_load_c) begin
         p_lat  <= p_sane_c;
         pe_lat <= par_en;
      end
   end

   always_comb begin
      state_n     = state;
      cfg_load_c  = 1'b0;
      cnt_en_c    = 1'b1;
      cnt_clear_c = 1'b0;
      cnt_load1_c = 1'b0;
      dat_samp_en = 1'b0;
      deser_en    = 1'b0;
      strt_chk_en = 1'b0;
      par_chk_en  = 1'b0;
      stp_chk_en  = 1'b0;
      data_valid  = 1'b0;
      case (state)
         IDLE: begin
            cnt_en_c    = 1'b0;
            cnt_clear_c = 1'b1;
            if (!rx_in) begin
               state_n    = START;
               cfg_load_c = 1'b1;
            end
         end
         START: begin
            dat_samp_en = 1'b1;
            strt_chk_en = pre_last_c;
            if (last_edge_c) begin
               if (strt_glitch) begin
                  state_n     = IDLE;
                  cnt_clear_c = 1'b1;
               end else begin
                  state_n = DATA;
               end
            end
         end
         DATA: begin
            dat_samp_en = 1'b1;
            deser_en    = last_edge_c;
            if (last_edge_c && last_data_c) begin
               state_n = pe_lat ? PARITY : STOP;
            end
         end
         PARITY: begin
            dat_samp_en = 1'b1;
            par_chk_en  = pre_last_c;
            if (last_edge_c) begin
               if (par_err) begin
                  state_n     = IDLE;
                  cnt_clear_c = 1'b1;
               end else begin
                  state_n = STOP;
               end
            end
         end
         STOP: begin
            dat_samp_en = 1'b1;
            stp_chk_en  = pre_last_c;
            if (last_edge_c) begin
               if (stp_err) begin
                  state_n     = IDLE;
                  cnt_clear_c = 1'b1;
               end else begin
                  state_n = VALID;
               end
            end
         end
         VALID: begin
            data_valid = 1'b1;
            // this cycle already serves as edge 0 of a back-to-back start bit
            if (!rx_in) begin
               state_n     = START;
               cfg_load_c  = 1'b1;
               cnt_load1_c = 1'b1;
            end else begin
               state_n     = IDLE;
               cnt_clear_c = 1'b1;
            end
         end
         default: begin
            state_n     = IDLE;
            cnt_clear_c = 1'b1;
         end
      endcase
   end

endmodule
